// File: rtl/bch_enc_ctrl_if.sv
// Port bundle between the BCH(15,7) sequencing controller, its message source,
// the serial encoder and the channel. BCH_ENC_CTRL_PAR_OUT_EN adds the parallel codeword port.
interface bch_enc_ctrl_if;
   localparam int unsigned K = 7;
   localparam int unsigned N = 15;

   logic [K-1:0] msg_data;
   logic         msg_valid;
   logic         msg_ready;
   logic         enc_init;
   logic         enc_switch;
   logic         enc_din;
   logic         enc_dout;
   logic         ser_bit;
   logic         ser_valid;
   logic         ser_first;
   logic         ser_last;
   logic         busy;
`ifdef BCH_ENC_CTRL_PAR_OUT_EN
   logic [N-1:0] cw_data;
   logic         cw_valid;
`endif

   // Environment side: message source, encoder dout and channel sink.
   modport master (
      output msg_data, msg_valid, enc_dout,
      input  msg_ready, enc_init, enc_switch, enc_din,
      input  ser_bit, ser_valid, ser_first, ser_last, busy
`ifdef BCH_ENC_CTRL_PAR_OUT_EN
      , input cw_data, cw_valid
`endif
   );

   // Controller side.
   modport slave (
      input  msg_data, msg_valid, enc_dout,
      output msg_ready, enc_init, enc_switch, enc_din,
      output ser_bit, ser_valid, ser_first, ser_last, busy
`ifdef BCH_ENC_CTRL_PAR_OUT_EN
      , output cw_data, cw_valid
`endif
   );
endinterface

// File: rtl/bch_enc_ctrl.sv
// Sequencing controller for the serial BCH(15,7) LFSR encoder: INIT, 7 message bits, 8 parity bits.
// Optional parallel codeword capture is enabled with BCH_ENC_CTRL_PAR_OUT_EN.
module bch_enc_ctrl (
   input  logic         clk,
   input  logic         reset,
   bch_enc_ctrl_if.slave bus
);
   localparam int unsigned K_W   = 7;
   localparam int unsigned N_W   = 15;
   localparam int unsigned CNT_W = 3;
   localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(K_W - 1);
   localparam logic [CNT_W-1:0] PAR_LAST = CNT_W'(N_W - K_W - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_INIT = 2'd1,
      S_MSG  = 2'd2,
      S_PAR  = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [K_W-1:0]   sreg_q, sreg_d;
   logic             ready_q, ready_d;
   logic             init_q, init_d;
   logic             switch_q, switch_d;
   logic             din_q, din_d;
   logic             valid_q, valid_d;
   logic             first_q, first_d;
   logic             last_q, last_d;
   logic             busy_q, busy_d;
   logic             hs_c;

   // Reset gates acceptance so nothing is captured while reset is held.
   assign hs_c = bus.msg_valid && ready_q && !reset;

   // Next state plus next-cycle control outputs decoded from the next state.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sreg_d   = sreg_q;

      unique case (state_q)
         S_IDLE: begin
            if (hs_c) begin
               sreg_d  = bus.msg_data;
               cnt_d   = '0;
               state_d = S_INIT;
            end
         end
         S_INIT: begin
            cnt_d   = '0;
            state_d = S_MSG;
         end
         S_MSG: begin
            sreg_d = {sreg_q[K_W-2:0], 1'b0};
            if (cnt_q == MSG_LAST) begin
               cnt_d   = '0;
               state_d = S_PAR;
            end else begin
               cnt_d = CNT_W'(cnt_q + CNT_W'(1));
            end
         end
         S_PAR: begin
            cnt_d = CNT_W'(cnt_q + CNT_W'(1));
            if (cnt_q == PAR_LAST) begin
               if (hs_c) begin
                  sreg_d  = bus.msg_data;
                  cnt_d   = '0;
                  state_d = S_INIT;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase

      ready_d  = (state_d == S_IDLE) || ((state_d == S_PAR) && (cnt_d == PAR_LAST));
      init_d   = (state_d == S_INIT);
      switch_d = (state_d == S_MSG);
      din_d    = (state_d == S_MSG) && sreg_d[K_W-1];
      valid_d  = (state_d == S_MSG) || (state_d == S_PAR);
      first_d  = (state_d == S_MSG) && (cnt_d == '0);
      last_d   = (state_d == S_PAR) && (cnt_d == PAR_LAST);
      busy_d   = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         sreg_q   <= '0;
         ready_q  <= 1'b1;
         init_q   <= 1'b0;
         switch_q <= 1'b0;
         din_q    <= 1'b0;
         valid_q  <= 1'b0;
         first_q  <= 1'b0;
         last_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sreg_q   <= sreg_d;
         ready_q  <= ready_d;
         init_q   <= init_d;
         switch_q <= switch_d;
         din_q    <= din_d;
         valid_q  <= valid_d;
         first_q  <= first_d;
         last_q   <= last_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.msg_ready  = ready_q && !reset;
   assign bus.enc_init   = init_q;
   assign bus.enc_switch = switch_q;
   assign bus.enc_din    = din_q;
   assign bus.ser_valid  = valid_q;
   assign bus.ser_first  = first_q;
   assign bus.ser_last   = last_q;
   assign bus.busy       = busy_q;
   // Encoder output passes straight through; the only combinational output path.
   assign bus.ser_bit    = valid_q && bus.enc_dout;

`ifdef BCH_ENC_CTRL_PAR_OUT_EN
   logic [N_W-2:0] cw_sh_q, cw_sh_d;
   logic [N_W-1:0] cw_data_q, cw_data_d;
   logic           cw_valid_q, cw_valid_d;

   // First 14 bits collect in cw_sh; the 15th completes the word on ser_last.
   always_comb begin
      cw_sh_d    = cw_sh_q;
      cw_data_d  = cw_data_q;
      cw_valid_d = last_q;
      if (valid_q) begin
         cw_sh_d = {cw_sh_q[N_W-3:0], bus.enc_dout};
      end
      if (last_q) begin
         cw_data_d = {cw_sh_q, bus.enc_dout};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cw_sh_q    <= '0;
         cw_data_q  <= '0;
         cw_valid_q <= 1'b0;
      end else begin
         cw_sh_q    <= cw_sh_d;
         cw_data_q  <= cw_data_d;
         cw_valid_q <= cw_valid_d;
      end
   end

   assign bus.cw_data  = cw_data_q;
   assign bus.cw_valid = cw_valid_q;
`endif
endmodule

// File: tb/tb_bch_enc_ctrl.sv
// Self-checking bench for bch_enc_ctrl with a behavioural BCH(15,7) encoder stand-in
// and a timeline reference model. Honours BCH_ENC_CTRL_PAR_OUT_EN.
module tb_bch_enc_ctrl;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   bch_enc_ctrl_if bus ();
   bch_enc_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   // Serial LFSR encoder stand-in, g(x) = x^8+x^7+x^6+x^4+1; starts with junk so INIT matters.
   logic [7:0] enc_r;
   initial enc_r = 8'($urandom);
   assign bus.enc_dout = bus.enc_switch ? bus.enc_din : enc_r[7];
   always @(posedge clk) begin
      if (bus.enc_init)                                   enc_r <= 8'h00;
      else if (bus.enc_switch && (bus.enc_din ^ enc_r[7])) enc_r <= {enc_r[6:0], 1'b0} ^ 8'hD1;
      else                                                enc_r <= {enc_r[6:0], 1'b0};
   end

   // Systematic codeword by polynomial long division.
   function automatic logic [14:0] cw_of(input logic [6:0] m);
      logic [14:0] r;
      r = {m, 8'h00};
      for (int i = 14; i >= 8; i--)
         if (r[i]) r = r ^ (15'(9'h1D1) << (i - 8));
      return {m, r[7:0]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference timeline: pos -1 idle, 0 INIT, 1..15 codeword bit index.
   int          pos = -1;
   logic [6:0]  m_msg = '0;
   logic        cw_pend = 1'b0;
   logic [14:0] cw_exp = '0;
   always @(posedge clk) begin
      if (reset) begin
         pos     <= -1;
         cw_pend <= 1'b0;
         cw_exp  <= '0;
      end else begin
         cw_pend <= (pos == 15);
         if (pos == 15) cw_exp <= cw_of(m_msg);
         if ((pos == -1 || pos == 15) && bus.msg_valid) begin
            pos   <= 0;
            m_msg <= bus.msg_data;
         end else if (pos == 15) pos <= -1;
         else if (pos >= 0)      pos <= pos + 1;
      end
   end

   // Monitor-side records for directed checks.
   logic [14:0] cap = '0, last_cw = '0;
   int n_last = 0, n_cwv = 0, bit_idx = 0;
   int cyc_first = 0, cyc_last = 0, gap_lf = 0, period = 0;
   logic rdy_at_last = 1'b0;

   always @(negedge clk) begin
      logic [14:0] c;
      logic e_sw, e_val, b;
      cyc++;
      if (chk_en) begin
         c     = cw_of(m_msg);
         e_sw  = (pos >= 1 && pos <= 7);
         e_val = (pos >= 1);
         b     = e_val ? c[15 - pos] : 1'b0;
         chk("msg_ready",  bus.msg_ready,  (pos == -1 || pos == 15) && !reset);
         chk("busy",       bus.busy,       pos != -1);
         chk("enc_init",   bus.enc_init,   pos == 0);
         chk("enc_switch", bus.enc_switch, e_sw);
         chk("enc_din",    bus.enc_din,    e_sw ? b : 1'b0);
         chk("ser_valid",  bus.ser_valid,  e_val);
         chk("ser_bit",    bus.ser_bit,    b);
         chk("ser_first",  bus.ser_first,  pos == 1);
         chk("ser_last",   bus.ser_last,   pos == 15);
`ifdef BCH_ENC_CTRL_PAR_OUT_EN
         chk("cw_valid",   bus.cw_valid,   cw_pend);
         chk("cw_data",    bus.cw_data,    cw_exp);
         if (bus.cw_valid) n_cwv++;
`endif
      end
      if (bus.ser_valid) begin
         cap = {cap[13:0], bus.ser_bit};
         bit_idx = bus.ser_first ? 1 : bit_idx + 1;
      end
      if (bus.ser_first) begin
         gap_lf    = cyc - cyc_last;
         period    = cyc - cyc_first;
         cyc_first = cyc;
      end
      if (bus.ser_last) begin
         last_cw     = cap;
         rdy_at_last = bus.msg_ready;
         cyc_last    = cyc;
         n_last++;
         chk("last_on_bit15", bit_idx, 15);
      end
   end

   task automatic send(input logic [6:0] m, input bit keep);
      bit ok;
      ok = 1'b0;
      bus.msg_data  = m;
      bus.msg_valid = 1'b1;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (bus.msg_ready) ok = 1'b1;
      end
      @(posedge clk); #1;
      if (!keep) bus.msg_valid = 1'b0;
      chk("handshake_in_time", ok, 1'b1);
   endtask

   task automatic wait_last(input int target);
      int k;
      k = 0;
      while (n_last < target && k < 60) begin
         @(posedge clk); #1;
         k++;
      end
      chk("ser_last_in_time", n_last >= target, 1'b1);
   endtask

   task automatic run_one(input logic [6:0] m, input logic [14:0] exp_cw);
      int t;
      t = n_last + 1;
      send(m, 1'b0);
      wait_last(t);
      chk("cw_serial", last_cw, exp_cw);
`ifdef BCH_ENC_CTRL_PAR_OUT_EN
      @(negedge clk);
      chk("cw_valid_pulse", bus.cw_valid, 1'b1);
      chk("cw_data_word",   bus.cw_data,  exp_cw);
`endif
      @(posedge clk); #1;
   endtask

   initial begin
      int t;
      int k;
      reset         = 1'b1;
      bus.msg_valid = 1'b1;
      bus.msg_data  = 7'h55;
      @(posedge clk); #1;
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset         = 1'b0;
      bus.msg_valid = 1'b0;
      @(negedge clk);
      chk("rst_msg_ready", bus.msg_ready, 1'b1);
      chk("rst_busy",      bus.busy,      1'b0);
      chk("rst_ser_valid", bus.ser_valid, 1'b0);
      chk("rst_enc_init",  bus.enc_init,  1'b0);
      @(posedge clk); #1;

      chk("model_00", cw_of(7'h00), 15'h0000);
      chk("model_01", cw_of(7'h01), 15'h01D1);
      chk("model_7f", cw_of(7'h7F), 15'h7FFF);

      run_one(7'h00, 15'h0000);
      run_one(7'h01, 15'h01D1);
      run_one(7'h7F, 15'h7FFF);

      // Back-to-back with msg_valid held high.
      t = n_last;
      send(7'h01, 1'b1);
      send(7'h7F, 1'b0);
      wait_last(t + 1);
      chk("b2b_cw1", last_cw, 15'h01D1);
      chk("b2b_ready_at_last", rdy_at_last, 1'b1);
      wait_last(t + 2);
      chk("b2b_cw2", last_cw, 15'h7FFF);
      chk("b2b_last_to_first", gap_lf, 2);
      chk("b2b_period", period, 16);
      repeat (3) @(posedge clk);
      #1;

      // Reset on the 5th message bit, then a fresh codeword must be clean.
      t = n_last;
      k = n_cwv;
      send(7'h01, 1'b0);
      for (int i = 0; i < 40 && !bus.ser_first; i++) @(negedge clk);
      chk("mid_first_seen", bus.ser_first, 1'b1);
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("mid_no_ser_last", n_last, t);
`ifdef BCH_ENC_CTRL_PAR_OUT_EN
      chk("mid_no_cw_valid", n_cwv, k);
`endif
      run_one(7'h7F, 15'h7FFF);

      // Random traffic with occasional resets; the compare process checks every cycle.
      repeat (3000) begin
         @(posedge clk); #1;
         reset         = ($urandom_range(0, 199) == 0);
         bus.msg_valid = ($urandom_range(0, 3) != 0);
         bus.msg_data  = 7'($urandom);
      end
      reset         = 1'b0;
      bus.msg_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
      $fatal(1);
   end
endmodule

// File: doc/bch_enc_ctrl.md
# bch_enc_ctrl

Sequencing controller for the serial BCH(15,7) LFSR encoder. It accepts one 7-bit message per valid/ready handshake and clears the encoder. It then drives the encoder's din/switch/init controls for 7 message cycles followed by 8 parity cycles, and presents the resulting 15-bit serial codeword with framing strobes. It sits between the message source and the serial channel/modulator, and is the only block that drives the encoder's control pins.

## Interface
- K, 7, message length; fixed by the encoder, only 7 supported.
- N, 15, codeword length; fixed by the encoder, only 15 supported.
- clk  input  1  rising-edge clock, shared with the encoder.
- reset  input  1  synchronous, active-high; clock clk.
- msg_data  input  7  message; msg_data[6] is transmitted first.
- msg_valid  input  1  message available.
- msg_ready  output  1  controller can accept; transfer occurs when msg_valid && msg_ready at a rising edge.
- enc_init  output  1  to encoder init; clears the LFSR.
- enc_switch  output  1  to encoder switch; 1 = message phase, 0 = parity phase.
- enc_din  output  1  to encoder din; current message bit, 0 outside the message phase.
- enc_dout  input  1  from encoder dout; combinational in the same cycle.
- ser_bit  output  1  codeword bit; equals enc_dout while ser_valid.
- ser_valid  output  1  ser_bit is a codeword bit.
- ser_first  output  1  first bit of a codeword.
- ser_last  output  1  15th bit of a codeword.
- busy  output  1  state is not IDLE.

## Operation
- State machine with states IDLE, INIT, MSG and PAR, plus a 3-bit bit counter `cnt` and a 7-bit message shift register `sreg`.
- **IDLE**
  - msg_ready=1.
  - On a handshake, capture msg_data into sreg, set cnt=0 and go to INIT.
- **INIT**
  - enc_init=1, enc_switch=0, enc_din=0.
  - Always lasts exactly 1 cycle, then goes to MSG.
- **MSG**
  - enc_switch=1, enc_din=sreg[6], ser_valid=1, ser_bit=enc_dout (equals enc_din).
  - Each cycle, sreg shifts left and cnt increments.
  - After cnt=6, set cnt=0 and go to PAR.
- **PAR**
  - enc_switch=0, enc_din=0, ser_valid=1, ser_bit=enc_dout (the parity bits, d7 first).
  - Lasts 8 cycles; cnt runs 0..7, and the counter wraps 7→0.
  - On the cnt=7 cycle:
    - ser_last=1 and msg_ready=1 (back-to-back acceptance).
    - If a handshake occurs, capture the message and go to INIT; otherwise go to IDLE.
- ser_first=1 only on the MSG cycle with cnt=0.
- Outside MSG and PAR: ser_valid, ser_first, ser_last, ser_bit and enc_din are all 0.
- Changes to msg_data or msg_valid while the controller is not ready are ignored; the captured message is frozen in sreg.
- No backpressure on the serial side. The encoder shifts every clock, so a codeword is never stalled once started.

## Timing
- **Reset**
  - At a rising edge with reset=1: state=IDLE, cnt=0, sreg=0.
  - msg_ready is gated by !reset, so no message is accepted while reset is high.
  - All other outputs are decoded from registered state. They are 0 after reset, except msg_ready=1 once reset deasserts.
- **Reset mid-codeword:** the codeword is abandoned with no ser_last. Because the next message always passes through INIT, the encoder is cleared before reuse.
- **Latency:** handshake at edge E → INIT in the cycle after E → ser_first in cycle E+2 → ser_last in cycle E+16.
- **Throughput:** 16 cycles per codeword with continuous msg_valid, consisting of 15 bits plus 1 INIT bubble.
- **Output path:** all control outputs are driven from registers (state, cnt, sreg). ser_bit is the only combinational path (enc_dout → ser_bit).

## Configuration
- Macro: BCH_ENC_CTRL_PAR_OUT_EN.
- **Defined:**
  - Adds output ports cw_data[14:0] and cw_valid.
  - Serial bits are also shifted into a 15-bit register, first bit ending at cw_data[14].
  - cw_valid pulses for 1 cycle, in the cycle after ser_last.
  - cw_data holds its value until the next cw_valid; it resets to 0.
  - A reset mid-codeword suppresses cw_valid for that codeword.
- **Undefined:** the ports and register are absent, and serial behaviour is identical.

## Test plan
- Reset held 3 cycles, then released → msg_ready=1, busy=0, ser_valid=0, enc_init=0; with msg_valid=1 during reset, no capture occurs.
- msg_data=7'h00 → 1 enc_init cycle, then 15 ser_valid bits all 0; ser_first on bit 1, ser_last on bit 15; cw_data=15'h0000 with the macro.
- msg_data=7'h01 → serial 0,0,0,0,0,0,1,1,1,0,1,0,0,0,1; cw_data=15'h01D1.
- msg_data=7'h7F → 15 ones; cw_data=15'h7FFF.
- msg_valid held high with messages 7'h01 then 7'h7F → msg_ready asserted on the ser_last cycle; the second ser_first occurs exactly 2 cycles after the first ser_last; period is 16 cycles; both codewords are correct.
- Reset asserted on the 5th MSG bit of 7'h01, then 7'h7F is sent → no ser_last and no cw_valid for the first message; the second codeword is 15'h7FFF, proving the encoder was re-initialised.
